// File: rtl/fg_packet_framer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fg_packet_framer_if
//  Brief    : Header, payload and framed-output stream bundle for the framer.
//  Revision : 1.0  initial release
// ============================================================================
interface fg_packet_framer_if #(
    parameter int DEST_WIDTH = 8,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic                  input_hdr_valid;
    logic                  input_hdr_ready;
    logic [DEST_WIDTH-1:0] input_hdr_dest;

    logic [DATA_WIDTH-1:0] input_payload_tdata;
    logic [KEEP_WIDTH-1:0] input_payload_tkeep;
    logic                  input_payload_tvalid;
    logic                  input_payload_tready;
    logic                  input_payload_tlast;
    logic                  input_payload_tuser;

    logic [DATA_WIDTH-1:0] output_tdata;
    logic [KEEP_WIDTH-1:0] output_tkeep;
    logic                  output_tvalid;
    logic                  output_tready;
    logic                  output_tlast;
    logic                  output_tuser;

    // Framer side
    modport slave (
        input  input_hdr_valid, input_hdr_dest,
        input  input_payload_tdata, input_payload_tkeep, input_payload_tvalid,
        input  input_payload_tlast, input_payload_tuser,
        input  output_tready,
        output input_hdr_ready, input_payload_tready,
        output output_tdata, output_tkeep, output_tvalid, output_tlast, output_tuser
    );

    // Generator / sink side
    modport master (
        output input_hdr_valid, input_hdr_dest,
        output input_payload_tdata, input_payload_tkeep, input_payload_tvalid,
        output input_payload_tlast, input_payload_tuser,
        output output_tready,
        input  input_hdr_ready, input_payload_tready,
        input  output_tdata, output_tkeep, output_tvalid, output_tlast, output_tuser
    );
endinterface
`default_nettype wire

// File: rtl/fg_packet_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fg_packet_framer
//  Brief    : Prepends a {dest, sequence number} header beat to each payload
//             packet and forwards the framed stream through a skid-buffered
//             output register.
//  Revision : 1.0  initial release
// ============================================================================
module fg_packet_framer #(
    parameter int DEST_WIDTH = 8,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    fg_packet_framer_if.slave bus,
    output logic             busy,
    output logic [31:0]      seq_num
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [31:0]           r_seq_num;
    logic                  r_hdr_ready;
    logic                  r_pay_ready;
    logic                  w_hdr_ready_next;
    logic                  w_pay_ready_next;

    logic [DATA_WIDTH-1:0] r_out_data;
    logic [KEEP_WIDTH-1:0] r_out_keep;
    logic                  r_out_last;
    logic                  r_out_user;
    logic                  r_out_valid;

    logic [DATA_WIDTH-1:0] r_skid_data;
    logic [KEEP_WIDTH-1:0] r_skid_keep;
    logic                  r_skid_last;
    logic                  r_skid_user;
    logic                  r_skid_valid;

    logic                  w_hdr_fire;
    logic                  w_pay_fire;
    logic                  w_in_fire;
    logic                  w_out_take;
    logic                  w_skid_valid_next;
    logic [DATA_WIDTH-1:0] w_in_data;
    logic [KEEP_WIDTH-1:0] w_in_keep;
    logic                  w_in_last;
    logic                  w_in_user;

    assign w_hdr_fire = bus.input_hdr_valid & r_hdr_ready;
    assign w_pay_fire = bus.input_payload_tvalid & r_pay_ready;
    assign w_in_fire  = w_hdr_fire | w_pay_fire;
    assign w_out_take = ~r_out_valid | bus.output_tready;

    // The skid entry only fills when a beat arrives while the output is stalled;
    // readies are derived from its next value so an occupied skid blocks input.
    assign w_skid_valid_next = w_out_take ? 1'b0 : (r_skid_valid | w_in_fire);

    always_comb begin
        w_in_data = '0;
        w_in_keep = '0;
        w_in_last = 1'b0;
        w_in_user = 1'b0;
        if (w_hdr_fire) begin
            w_in_data[31:0]              = r_seq_num;
            w_in_data[32 +: DEST_WIDTH]  = bus.input_hdr_dest;
            w_in_keep                    = '1;
        end else begin
            w_in_data = bus.input_payload_tdata;
            w_in_keep = bus.input_payload_tkeep;
            w_in_last = bus.input_payload_tlast;
            w_in_user = bus.input_payload_tuser;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Header ready needs a full IDLE cycle behind it, so a header never lands in
    // the same cycle as the preceding tlast.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_hdr_fire) w_state_next = ST_PAYLOAD;
            ST_PAYLOAD: if (w_pay_fire && bus.input_payload_tlast) w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
        w_hdr_ready_next = (r_state == ST_IDLE) && (w_state_next == ST_IDLE) && !w_skid_valid_next;
        w_pay_ready_next = (w_state_next == ST_PAYLOAD) && !w_skid_valid_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seq_num    <= '0;
            r_hdr_ready  <= 1'b0;
            r_pay_ready  <= 1'b0;
            r_out_data   <= '0;
            r_out_keep   <= '0;
            r_out_last   <= 1'b0;
            r_out_user   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_skid_data  <= '0;
            r_skid_keep  <= '0;
            r_skid_last  <= 1'b0;
            r_skid_user  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            r_hdr_ready <= w_hdr_ready_next;
            r_pay_ready <= w_pay_ready_next;
            if (w_hdr_fire) begin
                r_seq_num <= r_seq_num + 32'd1;
            end
            if (w_out_take) begin
                if (r_skid_valid) begin
                    r_out_data   <= r_skid_data;
                    r_out_keep   <= r_skid_keep;
                    r_out_last   <= r_skid_last;
                    r_out_user   <= r_skid_user;
                    r_out_valid  <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else if (w_in_fire) begin
                    r_out_data  <= w_in_data;
                    r_out_keep  <= w_in_keep;
                    r_out_last  <= w_in_last;
                    r_out_user  <= w_in_user;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_in_fire) begin
                r_skid_data  <= w_in_data;
                r_skid_keep  <= w_in_keep;
                r_skid_last  <= w_in_last;
                r_skid_user  <= w_in_user;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign bus.input_hdr_ready      = r_hdr_ready;
    assign bus.input_payload_tready = r_pay_ready;
    assign bus.output_tdata         = r_out_data;
    assign bus.output_tkeep         = r_out_keep;
    assign bus.output_tlast         = r_out_last;
    assign bus.output_tuser         = r_out_user;
    assign bus.output_tvalid        = r_out_valid;

    assign busy    = (r_state != ST_IDLE) | r_out_valid;
    assign seq_num = r_seq_num;

endmodule
`default_nettype wire
